// File: rtl/fp_unpack_sched.sv
// Shares one init_number unpacker between operands A and B of an FP op, then issues the pair.
// Define OPERAND_SWAP_EN to order the issued pair so that a_* holds the larger-magnitude operand.
//
// state | meaning
// IDLE  | waiting for an operand pair
// UNP_A | held A driven to the unpacker, capture into a_* when the wait expires
// UNP_B | held B driven to the unpacker, capture into b_* when the wait expires
// ISSUE | unpacked pair presented downstream, waiting for out_ready
module fp_unpack_sched #(
    parameter int TAG_W   = 4,
    parameter int UNP_LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      unp_number,
    input  logic             unp_sign,
    input  logic [7:0]       unp_exp,
    input  logic [27:0]      unp_ext_mantis,
    input  logic [2:0]       unp_type,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_sign,
    output logic [7:0]       a_exp,
    output logic [27:0]      a_ext_mantis,
    output logic [2:0]       a_type,
    output logic             b_sign,
    output logic [7:0]       b_exp,
    output logic [27:0]      b_ext_mantis,
    output logic [2:0]       b_type,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_swapped,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, UNP_A, UNP_B, ISSUE} state_t;

    // UNP_LAT is 0 or 1, so a single-bit wait counter is enough
    localparam logic LAT_LD = (UNP_LAT != 0);

    state_t           state, state_nxt;
    logic             wait_cnt, wait_nxt;
    logic [31:0]      hold_a, hold_b;
    logic [TAG_W-1:0] hold_tag;
    logic             accept, cap_a, cap_b, do_swap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        wait_nxt   = wait_cnt;
        in_ready   = 1'b0;
        unp_number = 32'h0;
        cap_a      = 1'b0;
        cap_b      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = UNP_A;
                    wait_nxt  = LAT_LD;
                end
            end
            UNP_A: begin
                unp_number = hold_a;
                if (wait_cnt == 1'b0) begin
                    cap_a     = 1'b1;
                    state_nxt = UNP_B;
                    wait_nxt  = LAT_LD;
                end else begin
                    wait_nxt = wait_cnt - 1'b1;
                end
            end
            UNP_B: begin
                unp_number = hold_b;
                if (wait_cnt == 1'b0) begin
                    cap_b     = 1'b1;
                    state_nxt = ISSUE;
                end else begin
                    wait_nxt = wait_cnt - 1'b1;
                end
            end
            ISSUE: begin
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        state_nxt = UNP_A;
                        wait_nxt  = LAT_LD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept    = in_valid & in_ready;
    assign out_valid = (state == ISSUE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_a   <= 32'h0;
            hold_b   <= 32'h0;
            hold_tag <= '0;
        end else if (accept) begin
            hold_a   <= in_a;
            hold_b   <= in_b;
            hold_tag <= in_tag;
        end
    end

`ifdef OPERAND_SWAP_EN
    // B is compared against the A already captured into a_*
    assign do_swap = (unp_exp > a_exp) ||
                     ((unp_exp == a_exp) && (unp_ext_mantis > a_ext_mantis));

    logic swapped_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swapped_q <= 1'b0;
        end else if (cap_b) begin
            swapped_q <= do_swap;
        end
    end
    assign out_swapped = swapped_q;
`else
    assign do_swap     = 1'b0;
    assign out_swapped = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sign       <= 1'b0;
            a_exp        <= 8'h0;
            a_ext_mantis <= 28'h0;
            a_type       <= 3'h0;
            b_sign       <= 1'b0;
            b_exp        <= 8'h0;
            b_ext_mantis <= 28'h0;
            b_type       <= 3'h0;
            out_tag      <= '0;
        end else begin
            if (cap_a) begin
                a_sign       <= unp_sign;
                a_exp        <= unp_exp;
                a_ext_mantis <= unp_ext_mantis;
                a_type       <= unp_type;
            end
            if (cap_b) begin
                out_tag <= hold_tag;
                if (do_swap) begin
                    a_sign       <= unp_sign;
                    a_exp        <= unp_exp;
                    a_ext_mantis <= unp_ext_mantis;
                    a_type       <= unp_type;
                    b_sign       <= a_sign;
                    b_exp        <= a_exp;
                    b_ext_mantis <= a_ext_mantis;
                    b_type       <= a_type;
                end else begin
                    b_sign       <= unp_sign;
                    b_exp        <= unp_exp;
                    b_ext_mantis <= unp_ext_mantis;
                    b_type       <= unp_type;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_unpack_sched.sv
// Bench for fp_unpack_sched: a transaction-level model checks the UNP_LAT=0 instance every cycle;
// a second instance with a registered unpacker covers UNP_LAT=1.
module tb_fp_unpack_sched;

    localparam int TAG_W = 4;
    localparam int LAT0  = 0;
`ifdef OPERAND_SWAP_EN
    localparam bit SWAP = 1'b1;
`else
    localparam bit SWAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic             in_valid, in_ready, out_valid, out_ready, busy, out_swapped;
    logic [31:0]      in_a, in_b, unp_number;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic             unp_sign, a_sign, b_sign;
    logic [7:0]       unp_exp, a_exp, b_exp;
    logic [27:0]      unp_ext_mantis, a_ext_mantis, b_ext_mantis;
    logic [2:0]       unp_type, a_type, b_type;

    logic             in_valid1, in_ready1, out_valid1, out_ready1, busy1, out_swapped1;
    logic [31:0]      in_a1, in_b1, unp_number1;
    logic [TAG_W-1:0] in_tag1, out_tag1;
    logic             unp_sign1, a_sign1, b_sign1;
    logic [7:0]       unp_exp1, a_exp1, b_exp1;
    logic [27:0]      unp_ext_mantis1, a_ext_mantis1, b_ext_mantis1;
    logic [2:0]       unp_type1, a_type1, b_type1;

    // Reference unpacker: {sign, exp, ext_mantis = {0, hidden, frac, 000}, type}
    function automatic logic [39:0] unpack(input logic [31:0] w);
        logic [7:0]  e;
        logic [22:0] f;
        logic [2:0]  t;
        e = w[30:23];
        f = w[22:0];
        if (e == 8'h00)      t = (f == 23'h0) ? 3'd0 : 3'd1;
        else if (e == 8'hFF) t = (f == 23'h0) ? 3'd3 : 3'd4;
        else                 t = 3'd2;
        return {w[31], e, 1'b0, (e != 8'h00), f, 3'b000, t};
    endfunction

    assign {unp_sign, unp_exp, unp_ext_mantis, unp_type} = unpack(unp_number);

    logic [39:0] unp1_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) unp1_q <= 40'h0;
        else        unp1_q <= unpack(unp_number1);
    end
    assign {unp_sign1, unp_exp1, unp_ext_mantis1, unp_type1} = unp1_q;

    fp_unpack_sched #(.TAG_W(TAG_W), .UNP_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .unp_number(unp_number),
        .unp_sign(unp_sign), .unp_exp(unp_exp), .unp_ext_mantis(unp_ext_mantis), .unp_type(unp_type),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_sign(a_sign), .a_exp(a_exp), .a_ext_mantis(a_ext_mantis), .a_type(a_type),
        .b_sign(b_sign), .b_exp(b_exp), .b_ext_mantis(b_ext_mantis), .b_type(b_type),
        .out_tag(out_tag), .out_swapped(out_swapped), .busy(busy)
    );

    fp_unpack_sched #(.TAG_W(TAG_W), .UNP_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .in_tag(in_tag1), .unp_number(unp_number1),
        .unp_sign(unp_sign1), .unp_exp(unp_exp1), .unp_ext_mantis(unp_ext_mantis1), .unp_type(unp_type1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .a_sign(a_sign1), .a_exp(a_exp1), .a_ext_mantis(a_ext_mantis1), .a_type(a_type1),
        .b_sign(b_sign1), .b_exp(b_exp1), .b_ext_mantis(b_ext_mantis1), .b_type(b_type1),
        .out_tag(out_tag1), .out_swapped(out_swapped1), .busy(busy1)
    );

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        int               acc;
    } txn_t;

    txn_t q[$];
    int   issue_tag[$];
    int   issue_cyc[$];
    int   cyc = 0;
    int   acc_cnt = 0;
    int   checks = 0;
    int   errors = 0;

    // Expected {a fields, b fields, swapped} for a pair
    function automatic logic [80:0] expect_out(input txn_t t);
        logic [39:0] ua, ub;
        ua = unpack(t.a);
        ub = unpack(t.b);
        if (SWAP && ((ub[38:31] > ua[38:31]) ||
                     ((ub[38:31] == ua[38:31]) && (ub[30:3] > ua[30:3]))))
            return {ub, ua, 1'b1};
        return {ua, ub, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Pair accepted at edge k: unpack A for UNP_LAT+1 cycles, B for UNP_LAT+1, then issue
    task automatic monitor();
        logic        bsy, eov, eir;
        logic [31:0] eun;
        logic [80:0] eo;
        int          d;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                bsy = (q.size() != 0);
                d   = bsy ? (cyc - q[0].acc) : 0;
                eov = bsy && (d >= 2 + 2 * LAT0);
                if (!bsy)                eun = 32'h0;
                else if (d <= LAT0)      eun = q[0].a;
                else if (d <= 2*LAT0+1)  eun = q[0].b;
                else                     eun = 32'h0;
                eir = !bsy || (eov && out_ready);
                chk("out_valid", out_valid, eov);
                chk("busy", busy, bsy);
                chk("in_ready", in_ready, eir);
                chk("unp_number", unp_number, eun);
                if (eov) begin
                    eo = expect_out(q[0]);
                    chk("a_fields", {a_sign, a_exp, a_ext_mantis, a_type}, eo[80:41]);
                    chk("b_fields", {b_sign, b_exp, b_ext_mantis, b_type}, eo[40:1]);
                    chk("out_swapped", out_swapped, eo[0]);
                    chk("out_tag", out_tag, q[0].tag);
                    if (out_ready) begin
                        issue_tag.push_back(int'(q[0].tag));
                        issue_cyc.push_back(cyc + 1);
                        void'(q.pop_front());
                    end
                end
                if (in_valid && eir) begin
                    q.push_back('{a: in_a, b: in_b, tag: in_tag, acc: cyc + 1});
                    acc_cnt++;
                end
            end
        end
    endtask

    // Presents a pair and returns 2 time units after the edge that accepted it; in_valid stays high
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
        int tgt, n;
        in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        tgt = acc_cnt + 1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (acc_cnt < tgt && n < 60);
        if (acc_cnt < tgt) chk("accept_timeout", acc_cnt, tgt);
        #2;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1 chk(name, busy, 1'b0);
        #1;
    endtask

    logic [80:0] snap;
    int          base, ib, hi_cnt;

    initial begin
        in_valid = 0; in_a = 0; in_b = 0; in_tag = 0; out_ready = 0;
        in_valid1 = 0; in_a1 = 0; in_b1 = 0; in_tag1 = 0; out_ready1 = 0;
        fork
            forever begin @(posedge clk); cyc++; end
            monitor();
            forever begin @(negedge rst_n); q.delete(); end
            begin
                #500000;
                $display("FAIL watchdog: simulation did not complete");
                $fatal(1);
            end
        join_none

        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_a_b", {a_sign, a_exp, a_ext_mantis, a_type, b_sign, b_exp, b_ext_mantis, b_type}, 80'h0);
        chk("rst_tag_swapped", {out_tag, out_swapped}, 5'h0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #2;

        // single op, latency 3 edges counting the accepting edge
        out_ready = 1'b1;
        in_a = 32'h3F800000; in_b = 32'h40000000; in_tag = 4'd5; in_valid = 1'b1;
        @(posedge clk); #1 chk("t2_ov_e1", out_valid, 1'b0);
        #1 in_valid = 1'b0;
        @(posedge clk); #1 chk("t2_ov_e2", out_valid, 1'b0);
        @(posedge clk); #1 chk("t2_ov_e3", out_valid, 1'b1);
        chk("t2_a_exp", a_exp, SWAP ? 8'h80 : 8'h7F);
        chk("t2_b_exp", b_exp, SWAP ? 8'h7F : 8'h80);
        chk("t2_out_tag", out_tag, 4'd5);
        chk("t2_out_swapped", out_swapped, SWAP);
        chk("t2_a_mant_type", {a_ext_mantis, a_type}, {28'h4000000, 3'd2});
        #1;
        wait_idle("t2_idle");

        // backpressure: -10.0 and 0.25 held for 10 cycles
        out_ready = 1'b0;
        send(32'hC1200000, 32'h3E800000, 4'd7);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("t4_reach_issue", out_valid, 1'b1);
        chk("t4_a_sign_exp", {a_sign, a_exp}, {1'b1, 8'h82});
        chk("t4_b_exp", b_exp, 8'h7D);
        snap = {a_sign, a_exp, a_ext_mantis, a_type, b_sign, b_exp, b_ext_mantis, b_type, out_swapped};
        #1;
        in_a = 32'h3F800000; in_b = 32'h3FC00000; in_tag = 4'd8; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("t4_stable",
                {a_sign, a_exp, a_ext_mantis, a_type, b_sign, b_exp, b_ext_mantis, b_type, out_swapped}, snap);
            chk("t4_tag_stable", out_tag, 4'd7);
            chk("t4_in_ready_low", in_ready, 1'b0);
        end
        base = acc_cnt;
        out_ready = 1'b1;
        #1 chk("t4_in_ready_comb", in_ready, 1'b1);
        @(posedge clk); #1 chk("t4_same_cycle_accept", acc_cnt, base + 1);
        #1 in_valid = 1'b0;
        wait_idle("t4_idle");
        chk("t4_last_tag", issue_tag[issue_tag.size()-1], 8);

        // back-to-back: equal, zero/NaN, denorm/-inf, 1.0/0.5
        send(32'h40400000, 32'h40400000, 4'd9);
        send(32'h00000000, 32'h7FC00000, 4'd10);
        send(32'h00400000, 32'hFF800000, 4'd11);
        send(32'h3F800000, 32'h3F000000, 4'd12);
        in_valid = 1'b0;
        wait_idle("t5_idle");
        ib = issue_tag.size() - 4;
        for (int i = 0; i < 4; i++) begin
            chk("t5_tag_order", issue_tag[ib+i], 9 + i);
            if (i > 0) chk("t5_spacing", issue_cyc[ib+i] - issue_cyc[ib+i-1], 3);
        end

        // reset while in UNP_B discards the pair
        send(32'h41000000, 32'h3F800000, 4'd3);
        in_valid = 1'b0;
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("t1_out_valid", out_valid, 1'b0);
        chk("t1_busy", busy, 1'b0);
        chk("t1_in_ready", in_ready, 1'b1);
        @(posedge clk); #3 rst_n = 1'b1;
        hi_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) hi_cnt++;
        end
        chk("t1_no_issue", hi_cnt, 0);
        #1;

        // UNP_LAT=1 instance: -3.0 then 1.0
        out_ready1 = 1'b1;
        in_a1 = 32'hC0400000; in_b1 = 32'h3F800000; in_tag1 = 4'd2; in_valid1 = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk); #1;
            chk("t6_out_valid", out_valid1, e == 5);
            if (e <= 2)      chk("t6_unp_a", unp_number1, 32'hC0400000);
            else if (e <= 4) chk("t6_unp_b", unp_number1, 32'h3F800000);
            if (e == 1) chk("t6_busy", busy1, 1'b1);
            #1 in_valid1 = 1'b0;
        end
        chk("t6_a_sign_exp", {a_sign1, a_exp1}, {1'b1, 8'h80});
        chk("t6_a_mant_type", {a_ext_mantis1, a_type1}, {28'h6000000, 3'd2});
        chk("t6_b_exp", b_exp1, 8'h7F);
        chk("t6_out_tag", out_tag1, 4'd2);
        chk("t6_swapped", out_swapped1, 1'b0);
        @(posedge clk); #1 chk("t6_ov_drop", out_valid1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
